// File: rtl/data_mem_arb_pkg.sv
// Shared types and defaults for the two-port data memory arbiter.
// Contents: arbiter state encoding, default address/data widths, and a
// helper that maps a port index to its grant state.
package data_mem_arb_pkg;

   localparam int unsigned ARB_AW_DEF = 8;
   localparam int unsigned ARB_DW_DEF = 8;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2
   } arb_state_t;

   // Grant state owned by the given port index.
   function automatic arb_state_t gnt_state(input logic port);
      return port ? ARB_GNT1 : ARB_GNT0;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin tie-break.
// Ports:
//   req    : request vector {Req1, Req0}
//   last   : index of the port served most recently
//   winner : port to grant (only meaningful when req != 0)
module rr_arb2
   import data_mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner
);

   // A lone requester wins outright; on a tie the port not served last wins.
   always_comb begin
      winner = 1'b0;
      if (req == 2'b11) begin
         winner = ~last;
      end else if (req[1]) begin
         winner = 1'b1;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two
// requesters (port 0: core load/store, port 1: loader/DMA).
// Optional feature: define DMARB_LOCK_EN to honour Lock0/Lock1 bursts;
// otherwise the Lock inputs are ignored.
// Ports:
//   Clk, Reset               : clock, async active-high reset
//   Req/Wr/Addr/WData/Lock x : requester x transaction (held until Gnt x)
//   Gntx                     : high while port x owns the memory
//   RdValidx / RDatax        : read completion pulse / held read data
//   MemWriteEn/MemAddress/MemDataIn : drive DataMem
//   MemDataOut               : DataMem combinational read data (MSB unused)
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int unsigned AW = ARB_AW_DEF,
   parameter int unsigned DW = ARB_DW_DEF
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Req0,
   input  logic          Wr0,
   input  logic [AW-1:0] Addr0,
   input  logic [DW-1:0] WData0,
   input  logic          Lock0,
   input  logic          Req1,
   input  logic          Wr1,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] WData1,
   input  logic          Lock1,
   output logic          Gnt0,
   output logic          Gnt1,
   output logic          RdValid0,
   output logic          RdValid1,
   output logic [DW-1:0] RData0,
   output logic [DW-1:0] RData1,
   output logic          MemWriteEn,
   output logic [AW-1:0] MemAddress,
   output logic [DW-1:0] MemDataIn,
   input  logic [DW:0]   MemDataOut
);

   arb_state_t state_q;
   arb_state_t state_nxt;
   logic       last_q;
   logic       last_nxt;
   logic       winner;
   logic       lock0_eff;
   logic       lock1_eff;
   logic       hs0;
   logic       hs1;

   // Burst lock qualification.
`ifdef DMARB_LOCK_EN
   assign lock0_eff = Lock0;
   assign lock1_eff = Lock1;
`else
   logic unused_lock;
   assign lock0_eff   = 1'b0;
   assign lock1_eff   = 1'b0;
   assign unused_lock = Lock0 | Lock1;
`endif

   // DataMem returns one bit wider than the data path; the extra bit is ignored.
   logic unused_dout_msb;
   assign unused_dout_msb = MemDataOut[DW];

   assign hs0 = (state_q == ARB_GNT0) & Req0;
   assign hs1 = (state_q == ARB_GNT1) & Req1;

   rr_arb2 u_rr_arb2 (
      .req    ({Req1, Req0}),
      .last   (last_q),
      .winner (winner)
   );

   // Next-state and round-robin pointer update.
   always_comb begin
      state_nxt = state_q;
      last_nxt  = last_q;
      case (state_q)
         ARB_IDLE: begin
            if (Req0 | Req1) begin
               state_nxt = gnt_state(winner);
            end
         end
         ARB_GNT0: begin
            last_nxt  = 1'b0;
            state_nxt = lock0_eff ? ARB_GNT0 : ARB_IDLE;
         end
         ARB_GNT1: begin
            last_nxt  = 1'b1;
            state_nxt = lock1_eff ? ARB_GNT1 : ARB_IDLE;
         end
         default: begin
            state_nxt = ARB_IDLE;
         end
      endcase
   end

   // State, pointer and grant flops; grants mirror the state they accompany.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ARB_IDLE;
         last_q  <= 1'b1;
         Gnt0    <= 1'b0;
         Gnt1    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         last_q  <= last_nxt;
         Gnt0    <= (state_nxt == ARB_GNT0);
         Gnt1    <= (state_nxt == ARB_GNT1);
      end
   end

   // Per-port read data capture at the edge that completes a read.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         RdValid0 <= 1'b0;
         RdValid1 <= 1'b0;
         RData0   <= '0;
         RData1   <= '0;
      end else begin
         RdValid0 <= hs0 & ~Wr0;
         RdValid1 <= hs1 & ~Wr1;
         if (hs0 & ~Wr0) begin
            RData0 <= MemDataOut[DW-1:0];
         end
         if (hs1 & ~Wr1) begin
            RData1 <= MemDataOut[DW-1:0];
         end
      end
   end

   // Memory mux follows the owner's live inputs so locked beats can change
   // address/data every cycle; quiet while idle and during reset.
   always_comb begin
      MemWriteEn = 1'b0;
      MemAddress = '0;
      MemDataIn  = '0;
      case (state_q)
         ARB_GNT0: begin
            MemWriteEn = Wr0;
            MemAddress = Addr0;
            MemDataIn  = WData0;
         end
         ARB_GNT1: begin
            MemWriteEn = Wr1;
            MemAddress = Addr1;
            MemDataIn  = WData1;
         end
         default: begin
            MemWriteEn = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares the single-port, single-address-pointer data memory between two masters, for example the core load/store path (port 0) and a loader/DMA engine (port 1). Each requester issues single-byte read or write transactions with a Req/Gnt handshake. The arbiter multiplexes address, write data and write enable onto the memory, returns registered read data per requester, and applies round-robin fairness. It sits between the requesters and DataMem and drives DataMem's WriteEn/DataAddress/DataIn.

## Interface
- AW, 8, address width (memory is 2^AW deep)
- DW, 8, data width
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Req0 / Req1  in  1  transaction request; once raised, held high with Wr/Addr/WData stable until Gnt seen
- Wr0 / Wr1  in  1  1 = write, 0 = read
- Addr0 / Addr1  in  AW  byte address
- WData0 / WData1  in  DW  write data
- Lock0 / Lock1  in  1  keep ownership for the next beat (burst); effective only with DMARB_LOCK_EN
- Gnt0 / Gnt1  out  1  registered; high during the cycle the requester owns the memory
- RdValid0 / RdValid1  out  1  one-cycle pulse, read data available
- RData0 / RData1  out  DW  read data, held until next read completes for that port
- MemWriteEn  out  1  to DataMem WriteEn
- MemAddress  out  AW  to DataMem DataAddress
- MemDataIn  out  DW  to DataMem DataIn
- MemDataOut  in  DW+1  from DataMem DataOut (combinational read); bit DW ignored

## Operation
- FSM states: ARB_IDLE, ARB_GNT0, ARB_GNT1. Gnt0 = (state==ARB_GNT0), Gnt1 = (state==ARB_GNT1).
- ARB_IDLE at edge: only Req0 -> GNT0; only Req1 -> GNT1; both -> the port != Last; neither -> stay.
- ARB_GNTx at edge: transaction x completes (handshake = Reqx & Gntx); Last <= x; next state is GNTx if Lockx (LOCK_EN only), else ARB_IDLE.
- Mem mux: in GNTx, MemAddress = Addrx, MemDataIn = WDatax, MemWriteEn = Wrx. In IDLE: all Mem outputs 0.
- Read: at the GNTx edge with Wrx=0, RDatax <= MemDataOut[DW-1:0], RdValidx <= 1 for the following cycle.
- Write: DataMem commits on the same edge that ends GNTx; RdValidx stays 0.
- Requester may not drop Req or change Wr/Addr/WData before its handshake (protocol violation, not checked).
- A locked owner must present its next beat (Req high, new Addr/WData) in the cycle after each handshake; the final beat has Lock=0.
- Reset values: state ARB_IDLE, Last=1 (port 0 wins first tie), Gnt*=0, RdValid*=0, RData*=0, Mem outputs 0.

## Timing
- Unlocked latency: Req seen at edge E0 -> Gnt cycle E0..E1 -> RdValid/RData in cycle E1..E2.
- Unlocked throughput: one transaction per 2 cycles (IDLE + GNT); with both requesting, strict alternation 0,1,0,1.
- Locked burst: one transaction per cycle, no IDLE between beats; the other port waits until the burst ends.
- Reset mid-GNT: state -> IDLE immediately (async), MemWriteEn drops, the pending write is not committed, no RdValid.
- Req arriving during the other port's GNT is served on the next arbitration, never dropped.

## Configuration
- DMARB_LOCK_EN defined: Lock0/Lock1 honored as above.
- Undefined: Lock inputs ignored; GNTx always returns to ARB_IDLE; ports remain present.

## Structure
- Package data_mem_arb_pkg: arb_state_t enum (ARB_IDLE, ARB_GNT0, ARB_GNT1), default AW/DW constants.
- One sub-module rr_arb2: inputs req[1:0], last; output winner. Pure tie-break logic, instantiated once.
- Top holds the FSM, Last register, memory mux and per-port read-data registers; DataMem is instantiated beside it, not inside.

## Test plan
- Reset, then Req0 write Addr0=0x10 WData0=0xA5 -> Gnt0 one cycle after Req, MemWriteEn=1 MemAddress=0x10 MemDataIn=0xA5 that cycle; then Req0 read 0x10 -> RdValid0 pulse, RData0=0xA5.
- Req0 and Req1 held for 4 reads each (addresses 0x00..0x03, 0x80..0x83) -> grants alternate 0,1,0,1,…; first grant to port 0; each port's RData matches the stored bytes.
- Lock1=1 for a 4-beat write burst to 0x20..0x23 while Req0 pending (DMARB_LOCK_EN) -> Gnt1 high 4 consecutive cycles, Gnt0 only after the burst; without the macro, Gnt1 is non-consecutive and interleaved with Gnt0.
- Assert Reset during a Gnt1 write to 0x30 (data 0x77), previously 0x00 -> MemWriteEn low immediately; readback of 0x30 returns 0x00; all outputs at reset values.
- MemDataOut bit 8 forced 1 during a read of 0x40 holding 0x3C -> RData=0x3C (bit ignored).
